// File: rtl/div_pkg.sv
// Shared types and constants for the sequential DIV/DIVU unit.
package div_pkg;

   localparam int unsigned DEF_WIDTH = 32;

   localparam logic [DEF_WIDTH-1:0] DIV0_Q       = '1;
   localparam logic [DEF_WIDTH-1:0] OVF_DIVIDEND = 32'h8000_0000;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StIter,
      StFix,
      StDone
   } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtract for restoring division; borrow set when a < b.
module div_trial_sub #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to lo, remainder to hi.
module div_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             Sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             dz,
   output logic             ovf
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, bmag_q, bmag_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic             mode_q, mode_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic             dz_q, dz_d, ovf_q, ovf_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, trial;
   logic             borrow;

   assign a_mag   = (mode_q && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag   = (mode_q && b_q[WIDTH-1]) ? -b_q : b_q;
   assign shifted = {rem_q, quo_q[WIDTH-1]};

   // 33-bit compare so divisors >= 2^31 are not mistaken for small values.
   div_trial_sub #(
      .W (WIDTH + 1)
   ) u_trial (
      .a      (shifted),
      .b      ({1'b0, bmag_q}),
      .diff   (trial),
      .borrow (borrow)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      bmag_d  = bmag_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      mode_d  = mode_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               mode_d  = Sign;
               state_d = StPrep;
            end
         end
         StPrep: begin
            if (b_q == '0) begin
               lo_d    = DIV0_Q;
               hi_d    = a_q;
               dz_d    = 1'b1;
               ovf_d   = 1'b0;
               state_d = StDone;
            end else begin
               quo_d   = a_mag;
               bmag_d  = b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               qneg_d  = mode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               rneg_d  = mode_q & a_q[WIDTH-1];
               state_d = StIter;
            end
         end
         StIter: begin
            rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~borrow};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            lo_d    = qneg_q ? -quo_q : quo_q;
            hi_d    = rneg_q ? -rem_q : rem_q;
            ovf_d   = mode_q && (a_q == OVF_DIVIDEND) && (b_q == '1);
            dz_d    = 1'b0;
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         bmag_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         mode_q  <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bmag_q  <= bmag_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         mode_q  <= mode_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
   assign done = (state_q == StDone);
   assign lo   = lo_q;
   assign hi   = hi_q;
   assign dz   = dz_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset, start, Sign;
   logic [31:0] A, B;
   logic        busy, done, dz, ovf;
   logic [31:0] lo, hi;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .Sign  (Sign),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .lo    (lo),
      .hi    (hi),
      .dz    (dz),
      .ovf   (ovf)
   );

   // Launch one operation; returns edges from start sample to done (-1 on timeout).
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
      @(negedge clk);
      Sign = s; A = a; B = b; start = 1'b1;
      @(posedge clk);
      lat = 1;
      busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; Sign = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done, dz, ovf} !== 4'b0 || lo !== 32'h0 || hi !== 32'h0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b dz=%b ovf=%b lo=%h hi=%h, expected all zero",
                  busy, done, dz, ovf, lo, hi);
      end
   endtask

   task automatic test_unsigned();
      int lat; logic bok;
      run_op(1'b0, 32'd100, 32'd7, lat, bok);
      checks++;
      if (lat !== 35) begin
         failures++; $display("FAIL unsigned_latency: got %0d expected 35", lat);
      end
      checks++;
      if (bok !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL unsigned_busy: busy_ok=%b busy_at_done=%b expected 1/0", bok, busy);
      end
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL unsigned_result: lo=%h hi=%h dz=%b ovf=%b expected 0000000e/00000002/0/0",
                  lo, hi, dz, ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
         failures++;
         $display("FAIL done_pulse: done=%b lo=%h hi=%h expected 0/0000000e/00000002", done, lo, hi);
      end
   endtask

   task automatic test_signed();
      int lat; logic bok;
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bok);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || lat !== 35) begin
         failures++;
         $display("FAIL signed: lo=%h hi=%h lat=%0d expected fffffffd/ffffffff/35", lo, hi, lat);
      end
   endtask

   task automatic test_wide_divisor();
      int lat; logic bok;
      run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, lat, bok);
      checks++;
      if (lo !== 32'd1 || hi !== 32'h7FFF_FFFE) begin
         failures++;
         $display("FAIL wide_divisor: lo=%h hi=%h expected 00000001/7ffffffe", lo, hi);
      end
   endtask

   task automatic test_overflow();
      int lat; logic bok;
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0 || ovf !== 1'b1 || dz !== 1'b0) begin
         failures++;
         $display("FAIL ovf_signed: lo=%h hi=%h ovf=%b dz=%b expected 80000000/00000000/1/0",
                  lo, hi, ovf, dz);
      end
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
      checks++;
      if (lo !== 32'h0 || hi !== 32'h8000_0000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_unsigned: lo=%h hi=%h ovf=%b expected 00000000/80000000/0", lo, hi, ovf);
      end
   endtask

   task automatic test_div_zero();
      int lat; logic bok;
      run_op(1'b0, 32'd5, 32'd0, lat, bok);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL div0_latency: got %0d expected 2", lat);
      end
      checks++;
      if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || dz !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL div0_result: lo=%h hi=%h dz=%b ovf=%b expected ffffffff/00000005/1/0",
                  lo, hi, dz, ovf);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      Sign = 1'b0; A = 32'd200; B = 32'd9; start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && lat < 100) begin
         start = (lat == 5);
         if (lat == 5) begin A = 32'd1000; B = 32'd3; end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (lo !== 32'd22 || hi !== 32'd2 || lat !== 35) begin
         failures++;
         $display("FAIL ignore_start: lo=%h hi=%h lat=%0d expected 00000016/00000002/35", lo, hi, lat);
      end
   endtask

   task automatic test_reset_mid();
      int seen; int lat; logic bok;
      @(negedge clk);
      Sign = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'h0 || hi !== 32'h0 || dz !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b done=%b lo=%h hi=%h dz=%b expected 0/0/0/0/0",
                  busy, done, lo, hi, dz);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++; $display("FAIL reset_no_done: activity cycles=%0d expected 0", seen);
      end
      run_op(1'b0, 32'd50, 32'd5, lat, bok);
      checks++;
      if (lo !== 32'd10 || hi !== 32'd0 || lat !== 35) begin
         failures++;
         $display("FAIL after_reset: lo=%h hi=%h lat=%0d expected 0000000a/00000000/35", lo, hi, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic bok;
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bok);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
         failures++;
         $display("FAIL b2b_first: lo=%h hi=%h expected fffffffd/00000001", lo, hi);
      end
      run_op(1'b0, 32'd1234, 32'd10, lat, bok);
      checks++;
      if (lo !== 32'd123 || hi !== 32'd4 || lat !== 35) begin
         failures++;
         $display("FAIL b2b_second: lo=%h hi=%h lat=%0d expected 0000007b/00000004/35", lo, hi, lat);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_wide_divisor();
      test_overflow();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
